mul_serial: RTL

//  Iterative shift-and-add multiplier, one partial product per clock; the inverse companion of the serial divider.

---
 rtl/mul_serial_pkg.sv | 11 +
 rtl/mul_serial.sv | 110 +++++++++++
 2 files changed

// File: rtl/mul_serial_pkg.sv
// Shared definitions for the serial shift-and-add multiplier.
// State encodings are fixed so that they line up with the serial divider.
package mul_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_serial.sv
// Iterative signed/unsigned multiplier that adds one partial product per clock.
// The operation takes a fixed DATA_W+1 cycles, ending with a sign-fix step.
//
// state | meaning
// IDLE  | result valid (done=1), waiting for start
// RUN   | one shift-and-add step per cycle, DATA_W steps
// FIX   | apply the result sign and register the product
module mul_serial
    import mul_serial_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [2*DATA_W-1:0] ACC_ONE  = (2*DATA_W)'(1);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0]   mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    counter;
    logic                neg;

    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     step_sum;
    logic                last_step;

    // -2^(DATA_W-1) negates to itself, which read as unsigned is the correct magnitude.
    always_comb begin
        mag_a = (signed_op && multiplicand[DATA_W-1]) ? -multiplicand : multiplicand;
        mag_b = (signed_op && multiplier[DATA_W-1])   ? -multiplier   : multiplier;
    end

    always_comb begin
        step_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
                  + (mplier_reg[0] ? {1'b0, mcand_reg} : {(DATA_W+1){1'b0}});
        last_step = (counter == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_RUN:  if (last_step) state_next = ST_FIX;
                ST_FIX:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            counter    <= '0;
            neg        <= 1'b0;
            product    <= '0;
        end else if (start) begin
            mcand_reg  <= mag_a;
            mplier_reg <= mag_b;
            acc        <= '0;
            counter    <= '0;
            neg        <= signed_op & (multiplicand[DATA_W-1] ^ multiplier[DATA_W-1]);
        end else begin
            case (state)
                ST_RUN: begin
                    // Carry out of the step adder becomes the new top bit after the shift.
                    acc        <= {step_sum, acc[DATA_W-1:1]};
                    mplier_reg <= mplier_reg >> 1;
                    counter    <= counter + CNT_ONE;
                end
                ST_FIX: begin
                    product <= neg ? (~acc + ACC_ONE) : acc;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_IDLE);

endmodule
